operand_feeder: RTL and testbench

Stream source that drives the operand input of a multiply node (the `mul_data`/`mul_stb`/`mul_ack` side). It reads float32 operands from a synchronous BRAM and emits them as groups of `cnt_max` operands over a strobe/acknowledge handshake, repeated for `num_groups` nodes. It is the transmitting end of the multiply node's operand interface and replaces the file-based operand reader for synthesis.

---
 rtl/operand_feeder.sv | 96 +++++++++
 tb/tb_operand_feeder.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/operand_feeder.sv
// operand_feeder: streams cnt_max x num_groups float32 operands from a sync BRAM over stb/ack.
// Ports: clk/rst (async active-low); start, base_addr, num_groups, cnt_max run request;
// mem_addr/mem_en/mem_rdata BRAM read port; output_z/output_z_stb/output_z_ack operand stream;
// idx position in group; last (only with FEEDER_LAST_EN) final operand of group; busy, done, state.
module operand_feeder #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_groups,
  input  logic [CNT_W-1:0]  cnt_max,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] output_z,
  output logic              output_z_stb,
  input  logic              output_z_ack,
  output logic [CNT_W-1:0]  idx,
`ifdef FEEDER_LAST_EN
  output logic              last,
`endif
  output logic              busy,
  output logic              done,
  output logic [2:0]        state
);
  typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, DONE} state_t;
  state_t st, st_nx;
  logic [ADDR_W-1:0] groups, grp;
  logic [CNT_W-1:0] cm;
  logic xfer, idx_end, grp_end;
  assign xfer    = st == SEND && output_z_stb && output_z_ack;
  assign idx_end = idx == cm - CNT_W'(1);
  assign grp_end = grp == groups - ADDR_W'(1);
  assign state   = st;
  always_comb begin
    st_nx = st;
    case (st)
      IDLE:    st_nx = !start ? IDLE : (cnt_max == '0 || num_groups == '0) ? DONE : READ;
      READ:    st_nx = WAIT;
      WAIT:    st_nx = SEND;
      SEND:    st_nx = !xfer ? SEND : (idx_end && grp_end) ? DONE : READ;
      default: st_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) st <= IDLE;
    else st <= st_nx;
  // mem_en/busy/done are registered from the next state so they line up with state
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mem_addr     <= '0;
      mem_en       <= 1'b0;
      output_z     <= '0;
      output_z_stb <= 1'b0;
      idx          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      groups       <= '0;
      grp          <= '0;
      cm           <= '0;
`ifdef FEEDER_LAST_EN
      last         <= 1'b0;
`endif
    end else begin
      mem_en <= st_nx == READ;
      busy   <= st_nx != IDLE;
      done   <= st_nx == DONE;
      if (st == IDLE && start) begin
        mem_addr <= base_addr;
        groups   <= num_groups;
        cm       <= cnt_max;
        idx      <= '0;
        grp      <= '0;
      end
      if (st == WAIT) begin
        output_z     <= mem_rdata;
        output_z_stb <= 1'b1;
`ifdef FEEDER_LAST_EN
        last         <= idx_end;
`endif
      end
      if (xfer) begin
        output_z_stb <= 1'b0;
        mem_addr     <= mem_addr + ADDR_W'(1);
        idx          <= idx_end ? '0 : idx + CNT_W'(1);
        grp          <= idx_end ? grp + ADDR_W'(1) : grp;
`ifdef FEEDER_LAST_EN
        last         <= 1'b0;
`endif
      end
    end
endmodule

// File: tb/tb_operand_feeder.sv
// tb_operand_feeder: directed bench for operand_feeder with a BRAM model and transfer monitor.
module tb_operand_feeder;
  logic clk = 0, rst = 0, start = 0, output_z_ack = 1;
  logic [7:0] base_addr = 0, num_groups = 0, mem_addr;
  logic [2:0] cnt_max = 0, idx, state;
  logic [31:0] mem_rdata = 0, output_z;
  logic mem_en, output_z_stb, busy, done;
`ifdef FEEDER_LAST_EN
  logic last;
`endif
  logic [31:0] mem [256];
  int checks = 0, failures = 0, cyc = 0, t0 = 0, dn = 0, lat;
  logic [31:0] xd[$];
  int xi[$], xt[$], ra[$], xl[$];
  operand_feeder dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_groups(num_groups),
    .cnt_max(cnt_max), .mem_addr(mem_addr), .mem_en(mem_en), .mem_rdata(mem_rdata),
    .output_z(output_z), .output_z_stb(output_z_stb), .output_z_ack(output_z_ack), .idx(idx),
`ifdef FEEDER_LAST_EN
    .last(last),
`endif
    .busy(busy), .done(done), .state(state)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en) mem_rdata <= mem[mem_addr];
  end
  always @(negedge clk) begin
    if (output_z_stb && output_z_ack) begin
      xd.push_back(output_z);
      xi.push_back(int'(idx));
      xt.push_back(cyc);
`ifdef FEEDER_LAST_EN
      xl.push_back(int'(last));
`endif
    end
    if (mem_en) ra.push_back(int'(mem_addr));
    if (done) dn++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_z"}, output_z, 0);
    check({tag, "_stb"}, 32'(output_z_stb), 0);
    check({tag, "_men"}, 32'(mem_en), 0);
    check({tag, "_maddr"}, 32'(mem_addr), 0);
    check({tag, "_idx"}, 32'(idx), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_state"}, 32'(state), 0);
`ifdef FEEDER_LAST_EN
    check({tag, "_last"}, 32'(last), 0);
`endif
  endtask
  task automatic stall_seq();
    for (int i = 0; i < 100 && xd.size() < 1; i++) @(posedge clk);
    #1 output_z_ack = 0;
    for (int i = 0; i < 20 && !output_z_stb; i++) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check("stall_z", output_z, 32'h40000000);
      check("stall_stb", 32'(output_z_stb), 1);
      check("stall_idx", 32'(idx), 1);
      if (k < 3) @(negedge clk);
    end
    @(posedge clk);
    #1 output_z_ack = 1;
  endtask
  task automatic glitch();
    repeat (3) begin
      repeat (5) @(posedge clk);
      #1 start = 1; base_addr = 8'h50; cnt_max = 1; num_groups = 1;
      @(posedge clk);
      #1 start = 0;
    end
  endtask
  task automatic wait_done(output int l);
    l = -1;
    for (int i = 0; i < 300 && l < 0; i++) begin
      @(negedge clk);
      if (done) l = cyc - t0;
    end
  endtask
  task automatic run(input logic [7:0] b, input logic [7:0] ng, input logic [2:0] cm,
                     input bit stall, input bit gl, input int exp_lat);
    xd.delete(); xi.delete(); xt.delete(); ra.delete(); xl.delete(); dn = 0;
    @(posedge clk);
    #1 base_addr = b; num_groups = ng; cnt_max = cm; start = 1;
    @(posedge clk);
    #1 start = 0; t0 = cyc;
    fork
      begin if (stall) stall_seq(); end
      begin if (gl) glitch(); end
      wait_done(lat);
    join
    check("latency", lat, exp_lat);
    @(negedge clk);
    check("done_pulse", 32'(dn), 1);
    check("post_done", 32'(done), 0);
    check("post_busy", 32'(busy), 0);
    check("post_state", 32'(state), 0);
    check("xfers", xd.size(), int'(cm) * int'(ng));
    check("reads", ra.size(), int'(cm) * int'(ng));
    for (int k = 0; k < xd.size() && k < int'(cm) * int'(ng); k++) begin
      check($sformatf("data%0d", k), xd[k], mem[(int'(b) + k) % 256]);
      check($sformatf("idx%0d", k), xi[k], k % int'(cm));
      check($sformatf("addr%0d", k), ra[k], (int'(b) + k) % 256);
      if (k > 0 && !stall) check($sformatf("gap%0d", k), xt[k] - xt[k-1], 3);
`ifdef FEEDER_LAST_EN
      check($sformatf("last%0d", k), xl[k], 32'(k % int'(cm) == int'(cm) - 1));
`endif
    end
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 | i;
    mem[0] = 32'h3F800000; mem[1] = 32'h40000000; mem[2] = 32'h40400000; mem[3] = 32'h40800000;
    mem[4] = 32'h40A00000; mem[5] = 32'h40C00000; mem[6] = 32'h40E00000; mem[7] = 32'h41000000;
    mem[8] = 32'h41100000; mem[9] = 32'h41200000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk);
    #1 rst = 1;
    run(8'h00, 8'd2, 3'd5, 0, 0, 30);
    run(8'h00, 8'd2, 3'd5, 1, 0, 34);
    run(8'hFE, 8'd1, 3'd3, 0, 0, 9);
    run(8'h10, 8'd2, 3'd0, 0, 0, 0);
    run(8'h10, 8'd0, 3'd5, 0, 0, 0);
    run(8'h20, 8'd2, 3'd3, 0, 0, 18);
    @(posedge clk);
    #1 base_addr = 8'h00; num_groups = 2; cnt_max = 5; start = 1;
    @(posedge clk);
    #1 start = 0;
    for (int i = 0; i < 20 && !output_z_stb; i++) @(negedge clk);
    check("pre_abort_stb", 32'(output_z_stb), 1);
    rst = 0;
    #1 check_idle("abort");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1;
    repeat (4) @(negedge clk);
    check("no_resume_busy", 32'(busy), 0);
    check("no_resume_men", 32'(mem_en), 0);
    run(8'h00, 8'd2, 3'd5, 0, 1, 30);
    repeat (10) @(negedge clk);
    check("idle_after_glitch", 32'(busy), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
